// File: rtl/iomem_cmd_master.sv
// rtl/iomem_cmd_master.sv - byte-stream command initiator for the PicoSoC iomem bus
module iomem_cmd_master #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic            is_write;
  logic [2:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     rdata_q;
  logic            cmd_fire;
  logic            rsp_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      rdata_q     <= '0;
      cmd_ready   <= 1'b0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= '0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            byte_cnt <= '0;
            busy     <= 1'b1;
            if (cmd_data == 8'h52 || cmd_data == 8'h57) begin
              is_write    <= (cmd_data == 8'h57);
              iomem_wdata <= '0;
              state       <= S_ADDR;
            end else begin
              // Unknown opcode: single error byte, nothing touches the bus.
              cmd_ready <= 1'b0;
              rsp_data  <= 8'hEE;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (cmd_fire) begin
            iomem_addr <= {cmd_data, iomem_addr[31:8]};
            byte_cnt   <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd3) begin
              byte_cnt <= '0;
              if (is_write) begin
                state <= S_WDATA;
              end else begin
                state       <= S_BUS;
                cmd_ready   <= 1'b0;
                iomem_valid <= 1'b1;
                iomem_wstrb <= 4'h0;
                to_cnt      <= '0;
              end
            end
          end
        end
        S_WDATA: begin
          if (cmd_fire) begin
            iomem_wdata <= {cmd_data, iomem_wdata[31:8]};
            byte_cnt    <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd3) begin
              byte_cnt    <= '0;
              state       <= S_BUS;
              cmd_ready   <= 1'b0;
              iomem_valid <= 1'b1;
              iomem_wstrb <= 4'hF;
              to_cnt      <= '0;
            end
          end
        end
        S_BUS: begin
          // A ready arriving on the final allowed cycle still wins over the abort.
          if (iomem_ready || to_cnt == TO_LAST) begin
            rdata_q     <= iomem_ready ? iomem_rdata : 32'h0;
            rsp_data    <= iomem_ready ? 8'h00 : 8'h01;
            rsp_valid   <= 1'b1;
            byte_cnt    <= is_write ? 3'd0 : 3'd4;
            iomem_valid <= 1'b0;
            iomem_wstrb <= 4'h0;
            state       <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            if (byte_cnt == 3'd0) begin
              rsp_valid <= 1'b0;
              rsp_data  <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              rsp_data <= rdata_q[7:0];
              rdata_q  <= {8'h00, rdata_q[31:8]};
              byte_cnt <= byte_cnt - 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_cmd_master.sv
// tb/tb_iomem_cmd_master.sv - directed bench with a transaction-level model of iomem_cmd_master
module tb_iomem_cmd_master;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = 32'h0;
  logic        busy;

  iomem_cmd_master #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: expected response bytes and the transaction the bus should carry.
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  bit          exp_bus = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_wstrb = 0;
  int          wait_n = 1000;
  logic [31:0] resp_rdata = 0;
  int          vcount = 0, last_vcount = 0, txn_cnt = 0;
  int          stall_rem = 0, rsp_idx = 0;
  bit          gaps = 0, noise = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = 0;
  logic [31:0] seen_addr = 0, seen_wdata = 0;
  logic [3:0]  seen_wstrb = 0;

  // Responder, response consumer and per-cycle compare, all between edges.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!resetn) begin
      vcount      = 0;
      prev_stall  = 0;
      iomem_ready = 1'b0;
      rsp_ready   = 1'b1;
    end else begin
      if (prev_stall) begin
        chk("rsp_held_valid", rsp_valid, 1);
        chk("rsp_held_data", rsp_data, prev_data);
      end
      if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      if (rsp_valid || iomem_valid) begin
        chk("cmd_ready_low", cmd_ready, 0);
        chk("busy_high", busy, 1);
      end
      if (iomem_valid) begin
        if (!exp_bus) chk("bus_spurious", iomem_valid, 0);
        chk("bus_addr", iomem_addr, exp_addr);
        chk("bus_wstrb", iomem_wstrb, exp_wstrb);
        if (exp_wstrb == 4'hF) chk("bus_wdata", iomem_wdata, exp_wdata);
        seen_addr = iomem_addr; seen_wdata = iomem_wdata; seen_wstrb = iomem_wstrb;
        vcount++;
        iomem_ready = (vcount == wait_n + 1);
        iomem_rdata = iomem_ready ? resp_rdata : $urandom;
      end else begin
        if (vcount > 0) begin
          last_vcount = vcount;
          txn_cnt++;
        end
        vcount = 0;
        iomem_ready = noise && ($urandom_range(0, 3) == 0);
        iomem_rdata = $urandom;
      end
      rsp_ready = 1'b1;
      if (rsp_valid && rsp_idx == 2 && stall_rem > 0) begin
        rsp_ready = 1'b0;
        stall_rem--;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_byte", rsp_data, e);
        end
        got_q.push_back(rsp_data);
        rsp_idx++;
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    cmd_data  = b;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_in_time", n < 200, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", n < 500, 1);
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wn, input logic [31:0] rd);
    bit ok;
    int n0;
    got_q.delete();
    rsp_idx    = 0;
    wait_n     = wn;
    resp_rdata = rd;
    ok         = (wn < TIMEOUT);
    exp_bus    = (op == 8'h52 || op == 8'h57);
    exp_addr   = addr;
    exp_wdata  = wdata;
    exp_wstrb  = (op == 8'h57) ? 4'hF : 4'h0;
    if (!exp_bus) exp_q.push_back(8'hEE);
    else begin
      exp_q.push_back(ok ? 8'h00 : 8'h01);
      if (op == 8'h52)
        for (int i = 0; i < 4; i++) exp_q.push_back(ok ? 8'(rd >> (8 * i)) : 8'h00);
    end
    n0 = txn_cnt;
    send_byte(op);
    if (exp_bus) begin
      for (int i = 0; i < 4; i++) send_byte(8'(addr >> (8 * i)));
      if (op == 8'h57)
        for (int i = 0; i < 4; i++) send_byte(8'(wdata >> (8 * i)));
    end
    wait_done();
    if (exp_bus) begin
      chk("txn_count", txn_cnt, n0 + 1);
      chk("valid_cycles", last_vcount, ok ? wn + 1 : TIMEOUT);
    end else begin
      chk("txn_count", txn_cnt, n0);
    end
    chk("idle_busy", busy, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outputs", {rsp_valid, rsp_data, iomem_valid, iomem_wstrb, busy}, 0);
    chk("rst_addr_wdata", {iomem_addr, iomem_wdata}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    do_cmd(8'h57, 32'h03000100, 32'h00000001, 0, 32'h0);
    chk("t1_rsp_len", got_q.size(), 1);
    chk("t1_rsp0", got_q[0], 8'h00);
    chk("t1_addr", seen_addr, 32'h03000100);
    chk("t1_wdata", seen_wdata, 32'h00000001);
    chk("t1_wstrb", seen_wstrb, 4'hF);
    chk("t1_vcycles", last_vcount, 1);

    noise = 1;
    do_cmd(8'h52, 32'h03000200, 32'h0, 3, 32'h12345678);
    chk("t2_rsp", {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4]}, 40'h0078563412);
    chk("t2_vcycles", last_vcount, 4);
    chk("t2_wstrb", seen_wstrb, 4'h0);

    do_cmd(8'h52, 32'h05000000, 32'h0, 1000, 32'h0);
    chk("t3_rsp", {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4]}, 40'h0100000000);
    chk("t3_vcycles", last_vcount, 8);

    do_cmd(8'hAA, 32'h0, 32'h0, 0, 32'h0);
    chk("t4_rsp_len", got_q.size(), 1);
    chk("t4_rsp0", got_q[0], 8'hEE);
    do_cmd(8'h57, 32'h02000004, 32'hCAFE0102, 1, 32'h0);

    gaps = 1;
    stall_rem = 5;
    do_cmd(8'h52, 32'h03000301, 32'h0, 1, 32'hA1B2C3D4);
    chk("t5_rsp", {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4]}, 40'h00D4C3B2A1);
    chk("t5_stall_used", stall_rem, 0);
    do_cmd(8'h57, 32'h03000008, 32'h55AA33CC, 7, 32'h0);
    gaps = 0;

    // Reset during the second wait cycle of a read.
    got_q.delete();
    rsp_idx   = 0;
    exp_bus   = 1;
    exp_addr  = 32'h03000004;
    exp_wstrb = 4'h0;
    wait_n    = 1000;
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'(exp_addr >> (8 * i)));
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_valid", iomem_valid, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_release_cmd_ready", cmd_ready, 1);
    chk("abort_no_rsp", got_q.size(), 0);
    do_cmd(8'h57, 32'h03000000, 32'hDEADBEEF, 2, 32'h0);
    chk("t6_rsp0", got_q[0], 8'h00);
    chk("t6_addr", seen_addr, 32'h03000000);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
